// File: rtl/lfsr_checker_if.sv
// Serial PRBS receive bus: data/valid/clear toward the checker, lock and error status back.
interface lfsr_checker_if #(
    parameter int ERR_W = 8
);
    logic             din;
    logic             din_valid;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output din, din_valid, clr_cnt,
        input  locked, err_pulse, err_cnt
    );

    modport slave (
        input  din, din_valid, clr_cnt,
        output locked, err_pulse, err_cnt
    );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising serial LFSR checker: hunts, verifies, then free-runs a reference
// and counts bit errors while locked.
module lfsr_checker #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] TAPS        = 'b110,
    parameter int               LOCK_CNT    = 4,
    parameter int               LOSS_THRESH = 2,
    parameter int               ERR_W       = 8
) (
    input  logic          clk,
    input  logic          set_n,
    lfsr_checker_if.slave bus
);
    localparam int FW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t           state;
    logic [WIDTH-1:0] h;          // h[0] is the newest bit
    logic [FW-1:0]    fill_cnt;
    logic [3:0]       match_cnt;
    logic [3:0]       bad_cnt;
    logic             locked_q;
    logic             pulse_q;
    logic [ERR_W-1:0] cnt_q;
    logic             p;
    logic             mis;

    assign p   = ^(h & TAPS);
    assign mis = bus.din ^ p;

    always_ff @(posedge clk or negedge set_n) begin
        if (!set_n) begin
            state     <= HUNT;
            h         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            bad_cnt   <= '0;
            locked_q  <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pulse_q <= 1'b0;
            if (bus.clr_cnt)
                cnt_q <= '0;
            if (bus.din_valid) begin
                case (state)
                    HUNT: begin
                        h        <= {h[WIDTH-2:0], bus.din};
                        fill_cnt <= fill_cnt + 1'b1;
                        if (fill_cnt == FW'(WIDTH - 1)) begin
                            state     <= VERIFY;
                            match_cnt <= '0;
                        end
                    end
                    VERIFY: begin
                        h <= {h[WIDTH-2:0], bus.din};
                        // an all-zero history predicts zero forever; never count it as a match
                        if (h == '0 || mis) begin
                            match_cnt <= '0;
                        end else begin
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt == 4'(LOCK_CNT - 1)) begin
                                state    <= LOCKED;
                                locked_q <= 1'b1;
                                bad_cnt  <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        // reference free-runs on its own prediction so one bad bit counts once
                        h <= {h[WIDTH-2:0], p};
                        if (mis) begin
                            pulse_q <= 1'b1;
                            if (bus.clr_cnt)
                                cnt_q <= ERR_W'(1);
                            else if (cnt_q != '1)
                                cnt_q <= cnt_q + 1'b1;
                            bad_cnt <= bad_cnt + 4'd1;
                            if (bad_cnt == 4'(LOSS_THRESH - 1)) begin
                                state    <= HUNT;
                                locked_q <= 1'b0;
                                fill_cnt <= '0;
                            end
                        end else begin
                            bad_cnt <= '0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = pulse_q;
    assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: an 8-bit and a 2-bit error-counter instance share one stimulus.
module tb_lfsr_checker;
    logic clk = 1'b0;
    logic set_n;
    always #5 clk = ~clk;

    lfsr_checker_if #(.ERR_W(8)) if8 ();
    lfsr_checker_if #(.ERR_W(2)) if2 ();

    assign if2.din       = if8.din;
    assign if2.din_valid = if8.din_valid;
    assign if2.clr_cnt   = if8.clr_cnt;

    lfsr_checker #(.WIDTH(3), .TAPS(3'b110), .LOCK_CNT(4), .LOSS_THRESH(2), .ERR_W(8)) dut8 (
        .clk(clk), .set_n(set_n), .bus(if8)
    );
    lfsr_checker #(.WIDTH(3), .TAPS(3'b110), .LOCK_CNT(4), .LOSS_THRESH(2), .ERR_W(2)) dut2 (
        .clk(clk), .set_n(set_n), .bus(if2)
    );

    typedef struct {
        logic din;
        logic vld;
        logic clr;
        logic lk;
        logic pl;
        int   cnt;
    } vec_t;

    vec_t tbl[83];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   idx   = 0;

    function automatic logic pat(input int k);
        logic [0:6] s;
        s = 7'b1110010;
        return s[k % 7];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic lk, input logic pl, input int c8);
        int c2;
        c2 = (c8 > 3) ? 3 : c8;
        chk({tag, " locked"}, 32'(if8.locked), 32'(lk));
        chk({tag, " locked2"}, 32'(if2.locked), 32'(lk));
        chk({tag, " pulse"}, 32'(if8.err_pulse), 32'(pl));
        chk({tag, " cnt8"}, 32'(if8.err_cnt), c8);
        chk({tag, " cnt2"}, 32'(if2.err_cnt), c2);
    endtask

    task automatic step(input logic d, input logic v, input logic c);
        @(negedge clk);
        if8.din       = d;
        if8.din_valid = v;
        if8.clr_cnt   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic clean();
        step(pat(idx), 1'b1, 1'b0);
        idx++;
    endtask

    task automatic bad(input logic c);
        step(~pat(idx), 1'b1, c);
        idx++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        if8.din_valid = 1'b0;
        if8.clr_cnt   = 1'b0;
        if8.din       = 1'b0;
        set_n         = 1'b0;
        @(negedge clk);
        set_n = 1'b1;
        idx   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lk_seen;
        int pl_seen;
        int nv;

        set_n         = 1'b0;
        if8.din       = 1'b0;
        if8.din_valid = 1'b0;
        if8.clr_cnt   = 1'b0;
        #2;
        check_all("reset", 1'b0, 1'b0, 0);
        @(negedge clk);
        set_n = 1'b1;

        // lock, long clean run, one isolated error, recovery
        for (int i = 0; i < 83; i++) begin
            tbl[i].din = pat(i);
            tbl[i].vld = 1'b1;
            tbl[i].clr = 1'b0;
            tbl[i].lk  = (i >= 6);
            tbl[i].pl  = 1'b0;
            tbl[i].cnt = (i >= 77) ? 1 : 0;
        end
        tbl[77].din = ~pat(77);
        tbl[77].pl  = 1'b1;

        idx = 0;
        for (int i = 0; i < 83; i++) begin
            step(tbl[i].din, tbl[i].vld, tbl[i].clr);
            idx++;
            check_all($sformatf("vec%0d", i), tbl[i].lk, tbl[i].pl, tbl[i].cnt);
        end

        // clear, then two consecutive bad bits drop lock, then relock
        step(pat(idx), 1'b1, 1'b1);
        idx++;
        check_all("clr_clean", 1'b1, 1'b0, 0);
        bad(1'b0);
        check_all("loss_bad1", 1'b1, 1'b1, 1);
        bad(1'b0);
        check_all("loss_bad2", 1'b0, 1'b1, 2);
        for (int k = 1; k <= 7; k++) begin
            clean();
            check_all($sformatf("relock%0d", k), (k == 7), 1'b0, 2);
        end

        // stuck-at-0 never locks
        do_reset();
        check_all("reset2", 1'b0, 1'b0, 0);
        lk_seen = 0;
        pl_seen = 0;
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 1'b1, 1'b0);
            if (if8.locked !== 1'b0) lk_seen++;
            if (if8.err_pulse !== 1'b0) pl_seen++;
        end
        chk("stuck0 locked", 32'(lk_seen), 0);
        chk("stuck0 pulse", 32'(pl_seen), 0);
        chk("stuck0 cnt", 32'(if8.err_cnt), 0);

        // gaps with X data
        do_reset();
        nv = 0;
        while (nv < 14) begin
            repeat ($urandom_range(0, 2)) begin
                step(1'bx, 1'b0, 1'b0);
                check_all($sformatf("gap_v%0d", nv), (nv >= 7), 1'b0, 0);
            end
            clean();
            nv++;
            check_all($sformatf("gapbit%0d", nv), (nv >= 7), 1'b0, 0);
        end

        // saturation and clear
        do_reset();
        repeat (7) clean();
        check_all("sat_lock", 1'b1, 1'b0, 0);
        for (int e = 1; e <= 5; e++) begin
            bad(1'b0);
            check_all($sformatf("sat_err%0d", e), 1'b1, 1'b1, e);
            clean();
            clean();
            check_all($sformatf("sat_hold%0d", e), 1'b1, 1'b0, e);
        end
        step(pat(idx), 1'b1, 1'b1);
        idx++;
        check_all("clr_alone", 1'b1, 1'b0, 0);
        bad(1'b1);
        check_all("clr_and_err", 1'b1, 1'b1, 1);

        // async reset between edges while locked with a pulse pending
        clean();
        bad(1'b0);
        check_all("pre_areset", 1'b1, 1'b1, 2);
        #2;
        set_n = 1'b0;
        if8.din_valid = 1'b0;
        #1;
        check_all("areset", 1'b0, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        set_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            clean();
            check_all($sformatf("post_rst%0d", k), (k == 7), 1'b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Serial PRBS checker for the LFSR pattern generator: receives one LFSR bit per valid cycle, self-synchronises to the sequence, then free-runs its own reference and counts bit errors. It sits at the receive end of any link or loopback driven by the LFSR generator and serves as its bench-side and in-system pass/fail monitor.

## Interface

- `WIDTH`, 3: LFSR length, which is also the history depth (2..16).
- `TAPS`, 3'b110: tap mask. Bit i-1 set means the delay-i bit feeds back: b[k] = XOR of b[k-i] over the set bits i. The default gives b[k] = b[k-2] ^ b[k-3], period 7.
- `LOCK_CNT`, 4: consecutive correct predictions needed to declare lock (1..15).
- `LOSS_THRESH`, 2: consecutive mismatches while locked that drop lock (1..15).
- `ERR_W`, 8: error counter width.
- `clk`  in  1  sole clock. All logic runs on the rising edge.
- `set_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  received serial LFSR bit.
- `din_valid`  in  1  `din` is sampled on the edge where this is 1. Gaps of any length are allowed.
- `clr_cnt`  in  1  synchronous clear of `err_cnt`.
- `locked`  out  1  1 while in LOCKED.
- `err_pulse`  out  1  one-cycle pulse per error counted.
- `err_cnt`  out  ERR_W  saturating count of errors while locked.

## Operation

- History `h[WIDTH:1]`, where `h[1]` is the newest bit. Prediction `p = ^(h & TAPS)`.
- States:
  - HUNT (reset state)
    - Each valid bit shifts `din` into `h` and increments `fill_cnt`.
    - At `fill_cnt == WIDTH`, go to VERIFY with `match_cnt = 0`.
  - VERIFY: each valid bit shifts `din` into `h`, so the checker stays self-synchronising.
    - `din == p` and `h` not all-zero: `match_cnt++`. When it reaches `LOCK_CNT`, go to LOCKED with `bad_cnt = 0`.
    - `din != p`: `match_cnt = 0`, stay in VERIFY.
    - `h` all-zero: `match_cnt` holds at 0. A stuck-at-0 stream must never lock.
  - LOCKED: each valid bit shifts `p` (not `din`) into `h`, so the reference free-runs and a single corrupted bit counts exactly once.
    - `din != p`: `err_cnt++` (saturating at all-ones), `err_pulse = 1`, `bad_cnt++`. When `bad_cnt` reaches `LOSS_THRESH`, go to HUNT with `fill_cnt = 0`.
    - `din == p`: `bad_cnt = 0`.
- `err_cnt` increments only in LOCKED. Mismatches in HUNT and VERIFY are not counted.
- `err_cnt` holds its value across a loss of lock; only `clr_cnt` or reset clears it.
- `clr_cnt` together with a counted error in the same cycle: `err_cnt` becomes 1 (clear, then count).
- `clr_cnt` has no effect on state, history or `locked`.
- `din_valid = 0`: all state, history and counters hold, and `err_pulse = 0`.
- `din` is ignored when `din_valid = 0`. X on `din` with `din_valid = 0` must not propagate.

## Timing

- Reset (`set_n = 0`, asynchronous, immediate): HUNT, and `h`, `fill_cnt`, `match_cnt`, `bad_cnt` = 0. Outputs: `locked = 0`, `err_pulse = 0`, `err_cnt = 0`.
- Deassertion takes effect from the first rising edge after `set_n` rises.
- Reset asserted mid-operation (any state): the same immediate return to reset values, with no partial count retained.
- All outputs are registered, with no combinational path from inputs to outputs.
- Lock latency: `locked` rises after the edge sampling valid bit number `WIDTH + LOCK_CNT` of a clean stream. With defaults, that is valid bit 7.
- `locked` falls after the edge sampling the `LOSS_THRESH`-th consecutive bad bit.
- `err_pulse` is high for exactly the cycle following the edge that sampled the bad bit. `err_cnt` updates on that same edge.
- The block accepts back-to-back valid bits every cycle. There is no backpressure.

## Test plan

- Lock: reset, then `din` = repeated 1110010 with `din_valid = 1` every cycle.
  - Required: `locked = 0` through bit 6, `locked = 1` after bit 7.
  - Then 70 further bits give `err_cnt = 0` and no `err_pulse`.
- Single error: after lock, invert one bit.
  - Required: exactly one `err_pulse`, `err_cnt = 1`, `locked` stays 1, and the following clean bits add no errors.
- Loss of lock: after lock, invert two consecutive bits.
  - Required: `err_cnt = 2`, `locked = 0` after the second bad bit.
  - Resuming the clean stream relocks 7 valid bits later, with `err_cnt` still 2.
- Stuck-at-0 / gaps:
  - 50 zero bits: `locked` never rises.
  - The clean pattern with random `din_valid` gaps (and `din = X` in the gaps) locks after 7 valid bits with no errors.
- Saturation and clear, with `ERR_W = 2`:
  - 5 isolated errors while locked: `err_cnt` = 3 and holds.
  - `clr_cnt` alone: `err_cnt` = 0.
  - `clr_cnt` on the same edge as an error: `err_cnt` = 1.
- Async reset: assert `set_n` low mid-LOCKED between clock edges.
  - Required: `locked`, `err_cnt` and `err_pulse` go to 0 immediately.
  - After release, relock takes 7 valid bits.
